// File: rtl/decoder_scan_driver_pkg.sv
// Shared types and helpers for the decoder scan driver: FSM states, slot count
// and the sizing rule for the dwell counter.
package scan_pkg;

  localparam int NUM_SLOTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BLANK  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // One counter serves both dwell phases, so it must hold the larger length.
  function automatic int cnt_width(input int prescale, input int blank);
    int longest;
    longest = (prescale > blank) ? prescale : blank;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/decoder_scan_driver_if.sv
// Control and select/enable bundle between the scan driver and its consumer
// (the integrating module that also feeds decoder_2_4).
interface decoder_scan_driver_if;
  import scan_pkg::*;

  logic                 run;
  logic [NUM_SLOTS-1:0] mask;
  logic [1:0]           s;
  logic                 en;
  logic                 frame;
  logic                 busy;

  modport master (
    input  run, mask,
    output s, en, frame, busy
  );

  modport slave (
    output run, mask,
    input  s, en, frame, busy
  );

endinterface

// File: rtl/decoder_scan_driver.sv
// Steps a 2-bit decoder select through all four slots, with blanking cycles
// before each slot so the select never moves while enable is high.
module decoder_scan_driver
  import scan_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  decoder_scan_driver_if.master bus
);

  localparam int             CW       = cnt_width(PRESCALE, BLANK);
  localparam bit             NO_BLANK = (BLANK == 0);
  localparam logic [CW-1:0]  LAST_ACT = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]  LAST_BLK = NO_BLANK ? '0 : CW'(BLANK - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]    s_q, s_n, s_inc;
  logic          en_q, en_n;
  logic          frame_q, frame_n;
  logic          busy_q, busy_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      s_q     <= '0;
      en_q    <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      s_q     <= s_n;
      en_q    <= en_n;
      frame_q <= frame_n;
      busy_q  <= busy_n;
    end
  end

  // Outputs are computed one cycle ahead and registered, so en for the next
  // cycle is derived from the mask bit of the slot that cycle will belong to.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    s_n     = s_q;
    s_inc   = s_q + 2'd1;
    en_n    = 1'b0;
    frame_n = 1'b0;
    busy_n  = busy_q;

    unique case (state)
      ST_IDLE: begin
        s_n    = '0;
        cnt_n  = '0;
        busy_n = 1'b0;
        if (bus.run) begin
          busy_n  = 1'b1;
          frame_n = 1'b1;
          if (NO_BLANK) begin
            state_n = ST_ACTIVE;
            en_n    = ~bus.mask[0];
          end else begin
            state_n = ST_BLANK;
          end
        end
      end

      ST_BLANK: begin
        if (cnt == LAST_BLK) begin
          cnt_n   = '0;
          state_n = ST_ACTIVE;
          en_n    = ~bus.mask[s_q];
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      ST_ACTIVE: begin
        if (cnt == LAST_ACT) begin
          cnt_n = '0;
          if (bus.run) begin
            s_n     = s_inc;
            frame_n = (s_q == 2'b11);
            if (NO_BLANK) begin
              en_n = ~bus.mask[s_inc];
            end else begin
              state_n = ST_BLANK;
            end
          end else begin
            state_n = ST_IDLE;
            s_n     = '0;
            busy_n  = 1'b0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
          en_n  = ~bus.mask[s_q];
        end
      end

      default: begin
        state_n = ST_IDLE;
        s_n     = '0;
        cnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.s     = s_q;
  assign bus.en    = en_q;
  assign bus.frame = frame_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
// Bench for decoder_scan_driver: default instance plus a PRESCALE=1/BLANK=0
// corner instance, both scored cycle by cycle against a slot-position model.
module tb_decoder_scan_driver;
  import scan_pkg::*;

  typedef struct {
    bit         busy;
    logic [1:0] s;
    int         pos;
    bit         frame;
    bit         en;
  } mstate_t;

  localparam mstate_t MZERO = '{busy: 1'b0, s: 2'b00, pos: 0, frame: 1'b0, en: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decoder_scan_driver_if bus0 ();
  decoder_scan_driver_if bus1 ();

  decoder_scan_driver #(.PRESCALE(4), .BLANK(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  decoder_scan_driver #(.PRESCALE(1), .BLANK(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int checks = 0;
  int passed = 0;
  mstate_t m0 = MZERO;
  mstate_t m1 = MZERO;
  mstate_t q0[$];
  mstate_t q1[$];
  bit started = 1'b0;

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, exp);
  endtask

  task automatic apply_stimulus(input bit r, input logic [3:0] mk);
    @(posedge clk);
    #1;
    bus0.run  = r;
    bus1.run  = r;
    bus0.mask = mk;
    bus1.mask = mk;
  endtask

  // A slot is b blanking positions followed by p active positions.
  function automatic mstate_t model_step(input mstate_t m, input bit run,
                                         input logic [3:0] mask, input int b, input int p);
    mstate_t n;
    n       = m;
    n.frame = 1'b0;
    if (!m.busy) begin
      if (run) begin
        n.busy  = 1'b1;
        n.s     = 2'b00;
        n.pos   = 0;
        n.frame = 1'b1;
      end
    end else if (m.pos == b + p - 1) begin
      if (run) begin
        n.s     = m.s + 2'd1;
        n.pos   = 0;
        n.frame = (n.s == 2'b00);
      end else begin
        n.busy = 1'b0;
        n.s    = 2'b00;
        n.pos  = 0;
      end
    end else begin
      n.pos = m.pos + 1;
    end
    n.en = n.busy && (n.pos >= b) && !mask[n.s];
    return n;
  endfunction

  always @(posedge clk) begin : model_blk
    mstate_t n0, n1;
    if (rst) begin
      n0 = MZERO;
      n1 = MZERO;
    end else begin
      n0 = model_step(m0, bus0.run, bus0.mask, 1, 4);
      n1 = model_step(m1, bus1.run, bus1.mask, 0, 1);
    end
    m0 <= n0;
    m1 <= n1;
    q0.push_back(n0);
    q1.push_back(n1);
    started <= 1'b1;
  end

  task automatic check_entry(input string dn, input mstate_t e, input logic [1:0] s,
                             input logic en, input logic frame, input logic busy);
    logic [7:0] dec_obs, dec_exp;
    dec_obs = en ? (8'd1 << s) : 8'd0;
    dec_exp = e.en ? (8'd1 << e.s) : 8'd0;
    check_output({dn, " s"},     {6'd0, s},     {6'd0, e.s});
    check_output({dn, " en"},    {7'd0, en},    {7'd0, e.en});
    check_output({dn, " frame"}, {7'd0, frame}, {7'd0, e.frame});
    check_output({dn, " busy"},  {7'd0, busy},  {7'd0, e.busy});
    check_output({dn, " dec"},   dec_obs,       dec_exp);
  endtask

  always @(negedge clk) begin : score_blk
    mstate_t e;
    if (started) begin
      if (q0.size() == 0 || q1.size() == 0) begin
        check_output("scoreboard empty", 8'(q0.size() + q1.size()), 8'd2);
      end else begin
        e = q0.pop_front();
        check_entry("d0", e, bus0.s, bus0.en, bus0.frame, bus0.busy);
        e = q1.pop_front();
        check_entry("d1", e, bus1.s, bus1.en, bus1.frame, bus1.busy);
      end
    end
  end

  // Frame-to-frame window: length plus en-high cycles (total and in slot 2).
  task automatic measure_frame(input int idx, output int period, output int en_cnt,
                               output int s2_en);
    int   t;
    logic f, e;
    logic [1:0] sv;
    period = 0;
    en_cnt = 0;
    s2_en  = 0;
    t      = 0;
    do begin
      @(negedge clk);
      t++;
      f = (idx == 0) ? bus0.frame : bus1.frame;
    end while (!f && t < 100);
    if (!f) begin
      period = -1;
      return;
    end
    do begin
      e  = (idx == 0) ? bus0.en : bus1.en;
      sv = (idx == 0) ? bus0.s  : bus1.s;
      if (e) en_cnt++;
      if (e && sv == 2'd2) s2_en++;
      period++;
      @(negedge clk);
      f = (idx == 0) ? bus0.frame : bus1.frame;
    end while (!f && period < 100);
    if (!f) period = -1;
  endtask

  initial begin : stim
    int period, en_cnt, s2_en, frames, t;
    bus0.run  = 1'b0;
    bus1.run  = 1'b0;
    bus0.mask = 4'b0000;
    bus1.mask = 4'b0000;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_output("idle busy", {7'd0, bus0.busy}, 8'd0);
    check_output("idle s",    {6'd0, bus0.s},    8'd0);

    apply_stimulus(1'b1, 4'b0000);
    measure_frame(0, period, en_cnt, s2_en);
    check_output("nominal period", 8'(period), 8'd20);
    check_output("nominal en cycles", 8'(en_cnt), 8'd16);
    measure_frame(1, period, en_cnt, s2_en);
    check_output("corner period", 8'(period), 8'd4);
    check_output("corner en cycles", 8'(en_cnt), 8'd4);

    apply_stimulus(1'b1, 4'b0100);
    repeat (25) @(posedge clk);
    measure_frame(0, period, en_cnt, s2_en);
    check_output("mask period", 8'(period), 8'd20);
    check_output("mask en cycles", 8'(en_cnt), 8'd12);
    check_output("mask slot2 en", 8'(s2_en), 8'd0);

    apply_stimulus(1'b1, 4'b0000);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus0.frame && t < 60);
    do begin @(negedge clk); t++; end while (!(bus0.s == 2'd1 && bus0.en) && t < 60);
    check_output("stop sync found", {7'd0, bus0.s == 2'd1 && bus0.en}, 8'd1);
    apply_stimulus(1'b0, 4'b0000);
    en_cnt = 0;
    frames = 0;
    t      = 0;
    do begin
      @(negedge clk);
      t++;
      if (bus0.en) en_cnt++;
      if (bus0.frame) frames++;
    end while (bus0.busy && t < 20);
    check_output("stop en tail", 8'(en_cnt), 8'd3);
    check_output("stop frames", 8'(frames), 8'd0);
    check_output("stop busy", {7'd0, bus0.busy}, 8'd0);
    check_output("stop s", {6'd0, bus0.s}, 8'd0);

    apply_stimulus(1'b1, 4'b0000);
    t = 0;
    do begin @(negedge clk); t++; end while (!bus0.frame && t < 60);
    do begin @(negedge clk); t++; end while (!(bus0.s == 2'd2 && bus0.en) && t < 60);
    check_output("reset sync found", {7'd0, bus0.s == 2'd2 && bus0.en}, 8'd1);
    #2 rst = 1'b1;
    #1;
    check_output("async rst en", {7'd0, bus0.en}, 8'd0);
    check_output("async rst s", {6'd0, bus0.s}, 8'd0);
    check_output("async rst busy", {7'd0, bus0.busy}, 8'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_output("post rst frame", {7'd0, bus0.frame}, 8'd1);
    check_output("post rst busy", {7'd0, bus0.busy}, 8'd1);
    measure_frame(0, period, en_cnt, s2_en);
    check_output("post rst period", 8'(period), 8'd20);

    apply_stimulus(1'b0, 4'b0000);
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
